// File: rtl/dds_sweep_ctrl.sv
// Stepped frequency-sweep scheduler feeding the DDS accumulator m/set load port.
// Optional `DDS_SWEEP_LOOP_EN: restart from start_m instead of finishing.
module dds_sweep_ctrl #(
  parameter int M_W     = 32,
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [M_W-1:0]     start_m,
  input  logic [M_W-1:0]     stop_m,
  input  logic [M_W-1:0]     step_m,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               go,
  input  logic               abort,
  output logic [M_W-1:0]     m,
  output logic               set,
  output logic               busy,
  output logic               done,
  output logic               error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [M_W-1:0]     m_q, m_d;
  logic [M_W-1:0]     stop_q, stop_d;
  logic [M_W-1:0]     step_q, step_d;
`ifdef DDS_SWEEP_LOOP_EN
  logic [M_W-1:0]     start_q, start_d;
`endif
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dw_q, dw_d;
  logic               set_q, set_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic               cfg_ok_s;
  logic [DWELL_W-1:0] dwell_eff_s;
  logic [M_W:0]       nxt_s;
  logic               nxt_ok_s;
  logic               step_end_s;

  // The extra carry bit keeps a wrapped tuning word from ever passing the bound check.
  assign cfg_ok_s    = (step_m != {M_W{1'b0}}) && (start_m <= stop_m);
  assign dwell_eff_s = (dwell == {DWELL_W{1'b0}}) ? CNT_ONE : dwell;
  assign nxt_s       = {1'b0, m_q} + {1'b0, step_q};
  assign nxt_ok_s    = (nxt_s <= {1'b0, stop_q});
  assign step_end_s  = (cnt_q == CNT_ONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!abort && go && cfg_ok_s) begin
          state_d = S_DWELL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DWELL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (step_end_s && !nxt_ok_s) begin
`ifdef DDS_SWEEP_LOOP_EN
          state_d = S_DWELL;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DWELL;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; done/busy change on the DWELL->DONE edge.
  always_comb begin
    m_d     = m_q;
    stop_d  = stop_q;
    step_d  = step_q;
`ifdef DDS_SWEEP_LOOP_EN
    start_d = start_q;
`endif
    cnt_d   = cnt_q;
    dw_d    = dw_q;
    set_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = {DWELL_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go && cfg_ok_s) begin
            m_d     = start_m;
            stop_d  = stop_m;
            step_d  = step_m;
`ifdef DDS_SWEEP_LOOP_EN
            start_d = start_m;
`endif
            dw_d    = dwell_eff_s;
            cnt_d   = dwell_eff_s;
            set_d   = 1'b1;
            busy_d  = 1'b1;
          end else if (go) begin
            error_d = 1'b1;
          end else begin
            busy_d = 1'b0;
          end
        end
        S_DWELL: begin
          if (step_end_s && nxt_ok_s) begin
            m_d   = nxt_s[M_W-1:0];
            set_d = 1'b1;
            cnt_d = dw_q;
          end else if (step_end_s) begin
`ifdef DDS_SWEEP_LOOP_EN
            m_d    = start_q;
            set_d  = 1'b1;
            cnt_d  = dw_q;
`else
            busy_d = 1'b0;
            done_d = 1'b1;
            cnt_d  = {DWELL_W{1'b0}};
`endif
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_DONE: begin
          busy_d = 1'b0;
        end
        default: begin
          busy_d = 1'b0;
          cnt_d  = {DWELL_W{1'b0}};
        end
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q     <= {M_W{1'b0}};
      stop_q  <= {M_W{1'b0}};
      step_q  <= {M_W{1'b0}};
`ifdef DDS_SWEEP_LOOP_EN
      start_q <= {M_W{1'b0}};
`endif
      cnt_q   <= {DWELL_W{1'b0}};
      dw_q    <= {DWELL_W{1'b0}};
      set_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      m_q     <= m_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
`ifdef DDS_SWEEP_LOOP_EN
      start_q <= start_d;
`endif
      cnt_q   <= cnt_d;
      dw_q    <= dw_d;
      set_q   <= set_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign m     = m_q;
  assign set   = set_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: vector table, directed corner sequences and
// randomized stimulus against a timestamp-based reference model.
module tb_dds_sweep_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] start_m, stop_m, step_m;
  logic [23:0] dwell;
  logic        go, abort;
  logic [31:0] m;
  logic        set, busy, done, error;

  int checks   = 0;
  int failures = 0;

  dds_sweep_ctrl #(.M_W(32), .DWELL_W(24)) dut (
    .clk(clk), .rst(rst), .start_m(start_m), .stop_m(stop_m), .step_m(step_m),
    .dwell(dwell), .go(go), .abort(abort), .m(m), .set(set), .busy(busy),
    .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: expected outputs, latched sweep and absolute time of the next step.
  logic [31:0] e_m;
  bit          e_set, e_busy, e_done, e_err;
  bit          running;
  logic [31:0] l_start, l_stop, l_step;
  longint      d_len, next_step, cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    e_m = 32'd0; e_set = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
    running = 1'b0; next_step = 0;
  endtask

  // Called at each rising edge with the inputs sampled there; produces next-cycle outputs.
  task automatic model_edge();
    bit          was_done;
    logic [32:0] nxt;
    was_done = e_done;
    e_set = 1'b0; e_done = 1'b0; e_err = 1'b0;
    if (rst) begin
      model_reset();
    end else if (abort) begin
      running = 1'b0;
      e_busy  = 1'b0;
    end else if (!running) begin
      if (go && !was_done) begin
        if (step_m != 32'd0 && start_m <= stop_m) begin
          running = 1'b1;
          l_start = start_m; l_stop = stop_m; l_step = step_m;
          d_len = (dwell == 24'd0) ? 1 : longint'(dwell);
          e_m = start_m; e_set = 1'b1; e_busy = 1'b1;
          next_step = cyc + 1 + d_len;
        end else begin
          e_err = 1'b1;
        end
      end
    end else if (cyc + 1 == next_step) begin
      nxt = 33'(e_m) + 33'(l_step);
      next_step = next_step + d_len;
      if (nxt <= 33'(l_stop)) begin
        e_m = nxt[31:0]; e_set = 1'b1;
      end else begin
`ifdef DDS_SWEEP_LOOP_EN
        e_m = l_start; e_set = 1'b1;
`else
        running = 1'b0; e_busy = 1'b0; e_done = 1'b1;
`endif
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("m", 64'(m), 64'(e_m));
    chk("set", 64'(set), 64'(e_set));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("error", 64'(error), 64'(e_err));
  endtask

  task automatic cfg(input logic [31:0] s, input logic [31:0] p, input logic [31:0] st,
                     input logic [23:0] dw);
    start_m = s; stop_m = p; step_m = st; dwell = dw;
  endtask

  typedef struct {
    logic [31:0] start;
    logic [31:0] stop;
    logic [31:0] step;
    logic [23:0] dw;
    bit          err;
    int          k;
    logic [31:0] last_m;
    int          dur;
  } vec_t;

  vec_t vec [8];
  int   nsets, dur;
  bit   got_done;
  logic [31:0] seen [$];

  initial begin
    cyc = 0;
    model_reset();
    rst = 1'b1; go = 1'b0; abort = 1'b0;
    cfg(32'd0, 32'd0, 32'd0, 24'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_m", 64'(m), 64'd0);
    chk("reset_outs", 64'({set, busy, done, error}), 64'd0);
    tick();
    rst = 1'b0;
    tick();

`ifndef DDS_SWEEP_LOOP_EN
    vec[0] = '{32'd100, 32'd260, 32'd50, 24'd4, 1'b0, 4, 32'd250, 16};
    vec[1] = '{32'd100, 32'd260, 32'd0, 24'd4, 1'b1, 0, 32'd250, 0};
    vec[2] = '{32'd10, 32'd5, 32'd1, 24'd2, 1'b1, 0, 32'd250, 0};
    vec[3] = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 24'd0, 1'b0, 1, 32'hFFFF_FFF0, 1};
    vec[4] = '{32'd0, 32'd0, 32'd1, 24'd2, 1'b0, 1, 32'd0, 2};
    vec[5] = '{32'd5, 32'd5, 32'hFFFF_FFFF, 24'd1, 1'b0, 1, 32'd5, 1};
    vec[6] = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 24'd3, 1'b0, 2, 32'h8000_0000, 6};
    vec[7] = '{32'd7, 32'd20, 32'd6, 24'd1, 1'b0, 3, 32'd19, 3};
    for (int i = 0; i < 8; i++) begin
      cfg(vec[i].start, vec[i].stop, vec[i].step, vec[i].dw);
      go = 1'b1;
      tick();
      go = 1'b0;
      chk("row_error", 64'(error), 64'(vec[i].err));
      chk("row_first_set", 64'(set), 64'(!vec[i].err));
      nsets = set ? 1 : 0;
      dur = 0;
      got_done = 1'b0;
      for (int c = 0; c < 200 && !got_done && !vec[i].err; c++) begin
        tick();
        dur++;
        if (set) nsets++;
        if (done) begin
          got_done = 1'b1;
          chk("row_done_busy", 64'(busy), 64'd0);
        end
      end
      chk("row_sets", 64'(nsets), 64'(vec[i].k));
      chk("row_last_m", 64'(m), 64'(vec[i].last_m));
      chk("row_done_seen", 64'(got_done), 64'(!vec[i].err));
      if (!vec[i].err) chk("row_duration", 64'(dur), 64'(vec[i].dur));
      tick();
      tick();
    end
`endif

    // Abort ten cycles after the first set.
    cfg(32'd0, 32'd1000, 32'd1, 24'd3);
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("abort_first_set", 64'(set), 64'd1);
    repeat (10) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_m", 64'(m), 64'd3);
    nsets = 0;
    got_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (set) nsets++;
      if (done) got_done = 1'b1;
    end
    chk("abort_no_set", 64'(nsets), 64'd0);
    chk("abort_no_done", 64'(got_done), 64'd0);

    // go together with abort in IDLE does nothing.
    cfg(32'd1, 32'd5, 32'd1, 24'd1);
    go = 1'b1; abort = 1'b1;
    tick();
    go = 1'b0; abort = 1'b0;
    chk("goabort_quiet", 64'({set, busy, error}), 64'd0);
    tick();

    // go and input changes during a sweep are ignored.
    cfg(32'd100, 32'd260, 32'd50, 24'd4);
    go = 1'b1;
    tick();
    go = 1'b0;
    seen.delete();
    if (set) seen.push_back(m);
    for (int c = 0; c < 40 && seen.size() < 4; c++) begin
      if (c == 5) begin
        go = 1'b1;
        cfg(32'd0, 32'd0, 32'd1, 24'd1);
      end else begin
        go = 1'b0;
      end
      tick();
      if (set) seen.push_back(m);
    end
    go = 1'b0;
    chk("ignore_count", 64'(seen.size()), 64'd4);
    for (int j = 0; j < seen.size() && j < 4; j++)
      chk("ignore_seq", 64'(seen[j]), 64'(100 + 50 * j));

    // Asynchronous reset in the middle of a sweep.
    cfg(32'd100, 32'd260, 32'd50, 24'd4);
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_m", 64'(m), 64'd0);
    chk("arst_outs", 64'({set, busy, done, error}), 64'd0);
    model_reset();
    tick();
    rst = 1'b0;
    tick();

`ifdef DDS_SWEEP_LOOP_EN
    cfg(32'd10, 32'd30, 32'd10, 24'd2);
    go = 1'b1;
    tick();
    go = 1'b0;
    seen.delete();
    got_done = 1'b0;
    if (set) seen.push_back(m);
    for (int c = 0; c < 30 && seen.size() < 7; c++) begin
      tick();
      if (set) seen.push_back(m);
      if (done) got_done = 1'b1;
    end
    chk("loop_count", 64'(seen.size()), 64'd7);
    for (int j = 0; j < seen.size() && j < 7; j++)
      chk("loop_seq", 64'(seen[j]), 64'(10 + 10 * (j % 3)));
    chk("loop_no_done", 64'(got_done), 64'd0);
    chk("loop_busy", 64'(busy), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("loop_abort_busy", 64'(busy), 64'd0);
    tick();
`endif

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          start_m = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
          stop_m  = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : start_m + 32'($urandom_range(0, 60));
          step_m  = 32'($urandom_range(0, 80));
        end else begin
          start_m = 32'($urandom_range(0, 200));
          stop_m  = start_m + 32'($urandom_range(0, 120)) - 32'd5;
          step_m  = 32'($urandom_range(0, 40));
        end
        dwell = 24'($urandom_range(0, 4));
      end
      go    = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 59) == 0);
      tick();
    end
    go = 1'b0;
    abort = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
